// File: rtl/multdiv_ctrl_pkg.sv
// Shared types for the multiply/divide sequencer, plus the op classifier used by
// both decode and multdiv_ctrl so the two cannot disagree on op semantics.
package multdiv_ctrl_pkg;

   localparam int MD_W = 32;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} md_state_t;
   typedef enum logic [1:0] {MK_MUL, MK_DIV, MK_NONE} md_kind_t;

   typedef enum logic [6:0] {
      OP_NONE  = 7'd0,
      OP_MULT  = 7'd1,
      OP_MULTU = 7'd2,
      OP_DIV   = 7'd3,
      OP_DIVU  = 7'd4,
      OP_MADD  = 7'd5,
      OP_MADDU = 7'd6,
      OP_MSUB  = 7'd7,
      OP_MSUBU = 7'd8,
      OP_MUL   = 7'd9,
      OP_ADD   = 7'd10
   } decoded_op_t;

   typedef struct packed {
      md_kind_t kind;
      logic     sgn;
      logic     acc;
      logic     sub;
      logic     gpr;
   } md_class_t;

   function automatic md_class_t md_classify(input decoded_op_t op);
      md_class_t c;
      c.kind = MK_NONE;
      c.sgn  = 1'b0;
      c.acc  = 1'b0;
      c.sub  = 1'b0;
      c.gpr  = 1'b0;
      case (op)
         OP_MULT:  begin c.kind = MK_MUL; c.sgn = 1'b1; end
         OP_MULTU: begin c.kind = MK_MUL; end
         OP_MADD:  begin c.kind = MK_MUL; c.sgn = 1'b1; c.acc = 1'b1; end
         OP_MADDU: begin c.kind = MK_MUL; c.acc = 1'b1; end
         OP_MSUB:  begin c.kind = MK_MUL; c.sgn = 1'b1; c.acc = 1'b1; c.sub = 1'b1; end
         OP_MSUBU: begin c.kind = MK_MUL; c.acc = 1'b1; c.sub = 1'b1; end
         OP_MUL:   begin c.kind = MK_MUL; c.sgn = 1'b1; c.gpr = 1'b1; end
         OP_DIV:   begin c.kind = MK_DIV; c.sgn = 1'b1; end
         OP_DIVU:  begin c.kind = MK_DIV; end
         default:  ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multdiv_ctrl_div_radix2.sv
// Unsigned restoring divider, one quotient bit per cycle; signs and aborts are
// handled by the caller, which drives clr to stop an iteration in progress.
module div_radix2
   import multdiv_ctrl_pkg::*;
#(
   parameter int DIV_ITERS = 32
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            clr,
   input  logic            start,
   input  logic [MD_W-1:0] dividend,
   input  logic [MD_W-1:0] divisor,
   output logic            done,
   output logic [MD_W-1:0] quotient,
   output logic [MD_W-1:0] remainder
);
   localparam int CW = $clog2(DIV_ITERS + 1);

   logic [CW-1:0]   r_cnt;
   logic            r_run;
   logic [MD_W-1:0] r_quo;
   logic [MD_W-1:0] r_rem;
   logic [MD_W-1:0] r_dvs;
   logic [MD_W:0]   w_shift;
   logic [MD_W:0]   w_trial;

   always_comb begin
      w_shift = {r_rem, r_quo[MD_W-1]};
      w_trial = w_shift - {1'b0, r_dvs};
   end

   // done flags the cycle whose edge performs the final iteration
   assign done      = r_run && (r_cnt == CW'(1));
   assign quotient  = r_quo;
   assign remainder = r_rem;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_run <= 1'b0;
         r_cnt <= '0;
      end else if (clr) begin
         r_run <= 1'b0;
         r_cnt <= '0;
      end else if (start) begin
         r_run <= 1'b1;
         r_cnt <= CW'(DIV_ITERS);
      end else if (r_run) begin
         r_cnt <= r_cnt - CW'(1);
         if (r_cnt == CW'(1)) r_run <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         r_quo <= dividend;
         r_rem <= '0;
         r_dvs <= divisor;
      end else if (r_run) begin
         r_quo <= {r_quo[MD_W-2:0], ~w_trial[MD_W]};
         r_rem <= w_trial[MD_W] ? w_shift[MD_W-1:0] : w_trial[MD_W-1:0];
      end
   end

endmodule

// File: rtl/multdiv_ctrl.sv
// Multi-cycle MIPS multiply/divide sequencer. Define MULTDIV_EARLY_DIV_EN to let
// divides with |dividend| < |divisor| finish in one cycle.
module multdiv_ctrl
   import multdiv_ctrl_pkg::*;
#(
   parameter int MUL_LAT   = 3,
   parameter int DIV_ITERS = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  decoded_op_t req_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic [63:0] hilo_in,
   input  logic        flush,
   output logic        busy,
   output logic        resp_valid,
   output logic [31:0] resp_hi,
   output logic [31:0] resp_lo,
   output logic        hi_we,
   output logic        lo_we,
   output logic        gpr_we
);
   localparam int MCW = $clog2(MUL_LAT + 1);

   function automatic logic [31:0] f_cneg(input logic [31:0] v, input logic neg);
      return neg ? (32'd0 - v) : v;
   endfunction

   md_state_t          r_state;
   logic [MCW-1:0]     r_mcnt;
   md_class_t          w_cls;
   md_class_t          r_cls;
   logic               w_accept;
   logic               w_div_zero;
   logic               w_div_early;
   logic               w_div_start;
   logic               w_div_done;
   logic [31:0]        w_mag_a;
   logic [31:0]        w_mag_b;
   logic [31:0]        w_quo;
   logic [31:0]        w_rem;
   logic [31:0]        r_a;
   logic               r_b_neg;
   logic [63:0]        r_hilo;
   logic               r_div_zero;
   logic               r_div_early;
   logic signed [63:0] w_a64;
   logic signed [63:0] w_b64;
   logic signed [63:0] w_prod;
   logic signed [63:0] w_acc;
   logic signed [63:0] r_prod_p [MUL_LAT];
   logic [31:0]        w_res_hi;
   logic [31:0]        w_res_lo;

   always_comb begin
      w_cls      = md_classify(req_op);
      w_accept   = req_valid && req_ready && !flush && (r_state == IDLE);
      w_mag_a    = f_cneg(src_a, w_cls.sgn && src_a[31]);
      w_mag_b    = f_cneg(src_b, w_cls.sgn && src_b[31]);
      w_div_zero = (src_b == 32'd0);
`ifdef MULTDIV_EARLY_DIV_EN
      w_div_early = !w_div_zero && (w_mag_a < w_mag_b);
`else
      w_div_early = 1'b0;
`endif
      w_div_start = w_accept && (w_cls.kind == MK_DIV) && !w_div_zero && !w_div_early;
      w_a64       = {{32{w_cls.sgn && src_a[31]}}, src_a};
      w_b64       = {{32{w_cls.sgn && src_b[31]}}, src_b};
      w_prod      = w_a64 * w_b64;
   end

   // Stage p0: product captured at acceptance; later stages only re-time it.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_cls       <= w_cls;
         r_a         <= src_a;
         r_b_neg     <= src_b[31];
         r_hilo      <= hilo_in;
         r_div_zero  <= w_div_zero;
         r_div_early <= w_div_early;
      end
      if (w_accept && (w_cls.kind == MK_MUL)) r_prod_p[0] <= w_prod;
      for (int i = 1; i < MUL_LAT; i++) r_prod_p[i] <= r_prod_p[i-1];
   end

   div_radix2 #(.DIV_ITERS(DIV_ITERS)) u_div (
      .clk       (clk),
      .resetn    (resetn),
      .clr       (flush),
      .start     (w_div_start),
      .dividend  (w_mag_a),
      .divisor   (w_mag_b),
      .done      (w_div_done),
      .quotient  (w_quo),
      .remainder (w_rem)
   );

   always_comb begin
      w_acc = r_prod_p[MUL_LAT-1];
      if (r_cls.acc) w_acc = r_cls.sub ? ($signed(r_hilo) - w_acc) : ($signed(r_hilo) + w_acc);
      w_res_hi = w_acc[63:32];
      w_res_lo = w_acc[31:0];
      if (r_cls.kind == MK_DIV) begin
         if (r_div_zero) begin
            w_res_lo = '1;
            w_res_hi = r_a;
         end else if (r_div_early) begin
            w_res_lo = '0;
            w_res_hi = r_a;
         end else begin
            w_res_lo = f_cneg(w_quo, r_cls.sgn && (r_a[31] ^ r_b_neg));
            w_res_hi = f_cneg(w_rem, r_cls.sgn && r_a[31]);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= IDLE;
         r_mcnt     <= '0;
         req_ready  <= 1'b1;
         busy       <= 1'b0;
         resp_valid <= 1'b0;
         resp_hi    <= '0;
         resp_lo    <= '0;
         hi_we      <= 1'b0;
         lo_we      <= 1'b0;
         gpr_we     <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         case (r_state)
            IDLE: if (w_accept) begin
               if (w_cls.kind == MK_MUL) begin
                  r_state   <= MUL;
                  r_mcnt    <= MCW'(MUL_LAT - 1);
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
               end else if (w_cls.kind == MK_DIV) begin
                  req_ready <= 1'b0;
                  if (w_div_zero || w_div_early) begin
                     r_state <= DONE;
                  end else begin
                     r_state <= DIV;
                     busy    <= 1'b1;
                  end
               end
            end
            MUL: if (flush) begin
               r_state   <= IDLE;
               req_ready <= 1'b1;
               busy      <= 1'b0;
            end else if (r_mcnt == '0) begin
               r_state <= DONE;
               busy    <= 1'b0;
            end else begin
               r_mcnt <= r_mcnt - MCW'(1);
            end
            DIV: if (flush) begin
               r_state   <= IDLE;
               req_ready <= 1'b1;
               busy      <= 1'b0;
            end else if (w_div_done) begin
               r_state <= DONE;
               busy    <= 1'b0;
            end
            DONE: begin
               r_state   <= IDLE;
               req_ready <= 1'b1;
               busy      <= 1'b0;
               if (!flush) begin
                  resp_valid <= 1'b1;
                  resp_hi    <= w_res_hi;
                  resp_lo    <= w_res_lo;
                  gpr_we     <= r_cls.gpr;
                  hi_we      <= !r_cls.gpr;
                  lo_we      <= !r_cls.gpr;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: arithmetic reference model with a per-cycle scoreboard
// plus directed vectors, flush and asynchronous reset scenarios.
module tb_multdiv_ctrl;
   import multdiv_ctrl_pkg::*;

   localparam int MUL_LAT   = 3;
   localparam int DIV_ITERS = 32;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        req_valid = 1'b0;
   logic        flush = 1'b0;
   decoded_op_t req_op = OP_NONE;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic [63:0] hilo_in = '0;
   logic        req_ready, busy, resp_valid, hi_we, lo_we, gpr_we;
   logic [31:0] resp_hi, resp_lo;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;
   int m_idle_from = 0;
   bit pend = 1'b0;
   int p_due = 0;
   logic [31:0] p_hi, p_lo;
   logic p_hwe, p_lwe, p_gwe;

   always #5 clk = ~clk;

   multdiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITERS(DIV_ITERS)) dut (
      .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .src_a(src_a), .src_b(src_b), .hilo_in(hilo_in),
      .flush(flush), .busy(busy), .resp_valid(resp_valid), .resp_hi(resp_hi),
      .resp_lo(resp_lo), .hi_we(hi_we), .lo_we(lo_we), .gpr_we(gpr_we)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain 64-bit integer arithmetic on the architectural operands.
   function automatic void model(input decoded_op_t op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] h, output bit ok, output int lat,
                                 output logic [31:0] hi, output logic [31:0] lo,
                                 output logic hwe, output logic lwe, output logic gwe);
      longint sa, sb, q, r;
      logic [63:0] p, res;
      bit sgn;
`ifdef MULTDIV_EARLY_DIV_EN
      logic [31:0] ma, mb;
`endif
      ok = 1'b1; lat = MUL_LAT + 1; hwe = 1'b1; lwe = 1'b1; gwe = 1'b0; res = '0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sgn = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_MUL) || (op == OP_DIV);
      if (sgn) p = sa * sb;
      else     p = {32'd0, a} * {32'd0, b};
      case (op)
         OP_MULT, OP_MULTU: res = p;
         OP_MADD, OP_MADDU: res = h + p;
         OP_MSUB, OP_MSUBU: res = h - p;
         OP_MUL: begin res = p; hwe = 1'b0; lwe = 1'b0; gwe = 1'b1; end
         OP_DIV, OP_DIVU: begin
            if (b == 32'd0) begin
               lat = 1;
               res = {a, 32'hFFFF_FFFF};
            end else begin
               lat = DIV_ITERS + 1;
               if (sgn) begin
                  q = sa / sb;
                  r = sa % sb;
                  res = {r[31:0], q[31:0]};
               end else begin
                  res = {a % b, a / b};
               end
`ifdef MULTDIV_EARLY_DIV_EN
               ma = (sgn && a[31]) ? -a : a;
               mb = (sgn && b[31]) ? -b : b;
               if (ma < mb) lat = 1;
`endif
            end
         end
         default: ok = 1'b0;
      endcase
      hi = res[63:32];
      lo = res[31:0];
   endfunction

   task automatic pin(input string name, input decoded_op_t op, input logic [31:0] a,
                      input logic [31:0] b, input logic [63:0] h, input int elat,
                      input logic [63:0] eres, input logic [2:0] ewe);
      bit ok; int lat; logic [31:0] mh, ml; logic hw, lw, gw;
      model(op, a, b, h, ok, lat, mh, ml, hw, lw, gw);
      chk({name, "_lat"}, 64'(lat), 64'(elat));
      chk({name, "_res"}, {mh, ml}, eres);
      chk({name, "_we"}, 64'({hw, lw, gw}), 64'(ewe));
   endtask

   // Scoreboard: advance the model on each edge, then check DUT outputs 1 time unit later.
   always @(posedge clk) begin
      bit ok; int lat; logic [31:0] mh, ml; logic hw, lw, gw;
      bit due_now;
      edge_n++;
      if (!resetn || flush) begin
         pend = 1'b0;
         m_idle_from = edge_n + 1;
      end else if (req_valid && (edge_n >= m_idle_from)) begin
         model(req_op, src_a, src_b, hilo_in, ok, lat, mh, ml, hw, lw, gw);
         if (ok) begin
            pend = 1'b1; p_due = edge_n + lat;
            p_hi = mh; p_lo = ml; p_hwe = hw; p_lwe = lw; p_gwe = gw;
            m_idle_from = edge_n + lat + 1;
         end
      end
      #1;
      due_now = pend && (p_due == edge_n);
      chk("resp_valid", 64'(resp_valid), 64'(due_now));
      chk("req_ready", 64'(req_ready), 64'(edge_n + 1 >= m_idle_from));
      chk("busy", 64'(busy), 64'(pend && (edge_n < p_due - 1)));
      if (due_now) begin
         chk("resp_lo", 64'(resp_lo), 64'(p_lo));
         if (p_hwe) chk("resp_hi", 64'(resp_hi), 64'(p_hi));
         chk("we_flags", 64'({hi_we, lo_we, gpr_we}), 64'({p_hwe, p_lwe, p_gwe}));
         pend = 1'b0;
      end
   end

   task automatic issue(input decoded_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] h);
      @(negedge clk);
      while (edge_n + 1 < m_idle_from) @(negedge clk);
      req_op = op; src_a = a; src_b = b; hilo_in = h; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      #1 resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_resp_hi", 64'(resp_hi), 64'd0);
      chk("rst_resp_lo", 64'(resp_lo), 64'd0);
      chk("rst_we", 64'({hi_we, lo_we, gpr_we}), 64'd0);
      resetn = 1'b1;

      pin("pin_mult",  OP_MULT,  32'hFFFF_FFFE, 32'd3, 64'd0, 4, 64'hFFFF_FFFF_FFFF_FFFA, 3'b110);
      pin("pin_maddu", OP_MADDU, 32'd1, 32'd1, 64'h0000_0001_FFFF_FFFF, 4, 64'h0000_0002_0000_0000, 3'b110);
      pin("pin_msub",  OP_MSUB,  32'd2, 32'd3, 64'd0, 4, 64'hFFFF_FFFF_FFFF_FFFA, 3'b110);
      pin("pin_div",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 64'd0, 33, 64'hFFFF_FFFF_FFFF_FFFD, 3'b110);
      pin("pin_divu",  OP_DIVU,  32'd100, 32'd7, 64'd0, 33, 64'h0000_0002_0000_000E, 3'b110);
      pin("pin_div0",  OP_DIVU,  32'd5, 32'd0, 64'd0, 1, 64'h0000_0005_FFFF_FFFF, 3'b110);
      pin("pin_mul",   OP_MUL,   32'd6, 32'd7, 64'd0, 4, 64'h0000_0000_0000_002A, 3'b001);
      pin("pin_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 33, 64'h0000_0000_8000_0000, 3'b110);

      issue(OP_MULT,  32'hFFFF_FFFE, 32'd3, 64'd0);
      issue(OP_MADDU, 32'd1, 32'd1, 64'h0000_0001_FFFF_FFFF);
      issue(OP_MSUB,  32'd2, 32'd3, 64'd0);
      issue(OP_DIV,   32'hFFFF_FFF9, 32'd2, 64'd0);
      issue(OP_DIVU,  32'd100, 32'd7, 64'd0);
      issue(OP_DIVU,  32'd5, 32'd0, 64'd0);
      issue(OP_DIVU,  32'd3, 32'd9, 64'd0);
      issue(OP_MUL,   32'd6, 32'd7, 64'd0);
      issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'd0);
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0);
      issue(OP_MADD,  32'hFFFF_FFFF, 32'd5, 64'd10);
      issue(OP_MSUBU, 32'h0001_0000, 32'h0001_0000, 64'd0);
      issue(OP_DIV,   32'd7, 32'hFFFF_FFFE, 64'd0);
      issue(OP_ADD,   32'd1, 32'd2, 64'd0);
      issue(OP_DIVU,  32'hFFFF_FFFF, 32'd1, 64'd0);

      // Request coincident with flush in IDLE must be dropped.
      @(negedge clk);
      while (edge_n + 1 < m_idle_from) @(negedge clk);
      req_op = OP_MULT; src_a = 32'd9; src_b = 32'd9; req_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; flush = 1'b0;

      // Flush at divide iteration 10, then a MULT right after.
      issue(OP_DIV, 32'd1000, 32'd3, 64'd0);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      req_op = OP_MULT; src_a = 32'hFFFF_FFFB; src_b = 32'd4; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;

      // Flush landing on the DONE cycle suppresses the response.
      issue(OP_MULT, 32'd11, 32'd13, 64'd0);
      repeat (3) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;

      // Leave nonzero HI and write enables, then reset in the middle of a divide.
      issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 64'd0);
      issue(OP_DIV, 32'd12345, 32'd17, 64'd0);
      repeat (5) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("arst_resp_valid", 64'(resp_valid), 64'd0);
      chk("arst_req_ready", 64'(req_ready), 64'd1);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_resp_hi", 64'(resp_hi), 64'd0);
      chk("arst_resp_lo", 64'(resp_lo), 64'd0);
      chk("arst_we", 64'({hi_we, lo_we, gpr_we}), 64'd0);
      @(negedge clk);
      resetn = 1'b1;

      issue(OP_DIVU, 32'd100, 32'd7, 64'd0);
      issue(OP_MUL, 32'hFFFF_FFFD, 32'd7, 64'd0);
      repeat (40) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer in the execute stage.
- Accepts one decoded MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU/MUL op at a time and runs it on a pipelined multiplier or an iterative radix-2 divider.
- Returns a 64-bit HI/LO result (plus LO-to-GPR for MUL) and holds the pipeline busy meanwhile.
- Exceptions and branch flushes abort it cleanly.

Parameters:
- MUL_LAT, 3: cycles from acceptance to result for multiply-class ops (>=1).
- DIV_ITERS, 32: divider iterations, one quotient bit per cycle; fixed 32 for MIPS32.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents an op
- req_ready  out  1  controller idle; request accepted when req_valid & req_ready
- req_op  in  7  decoded_op_t of the instruction
- src_a  in  32  rs value
- src_b  in  32  rt value
- hilo_in  in  64  current {HI,LO}, sampled at acceptance; used by MADD/MSUB family
- flush  in  1  abort current op and drop any request this cycle
- busy  out  1  op in flight; pipeline stalls on it
- resp_valid  out  1  one-cycle result pulse
- resp_hi  out  32  new HI
- resp_lo  out  32  new LO
- hi_we  out  1  write HI (qualified by resp_valid)
- lo_we  out  1  write LO (qualified by resp_valid)
- gpr_we  out  1  MUL: write resp_lo to rd (qualified by resp_valid)

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low; clock port clk, reset port resetn.
- Reset values: state IDLE; req_ready=1; busy=0; resp_valid=0; resp_hi/resp_lo=0; hi_we=lo_we=gpr_we=0.
- States: IDLE, MUL, DIV, DONE.
- Acceptance: in IDLE with req_valid & req_ready & !flush, latch op, operands and hilo_in.
  - Multiply-class op -> MUL with counter=MUL_LAT-1.
  - DIV/DIVU -> DIV.
  - Any other op -> ignored; stay IDLE, no response.
- MUL state:
  - Counter decrements each cycle; at 0 go to DONE.
  - Total latency acceptance-to-resp_valid = MUL_LAT+1 cycles.
  - MULT, MADD, MSUB, MUL use signed 32x32->64; MULTU, MADDU, MSUBU use unsigned.
  - MADD*: result = hilo + product. MSUB*: result = hilo - product. Both mod 2^64.
  - MUL: gpr_we=1, hi_we=lo_we=0, resp_lo = product[31:0]. All others: hi_we=lo_we=1.
- DIV state:
  - Signed DIV operates on magnitudes.
  - Quotient is negated when operand signs differ; remainder takes the dividend's sign.
  - Runs DIV_ITERS iterations, sign fix-up in the DONE transition; latency = DIV_ITERS+1 cycles.
  - Result: resp_lo = quotient, resp_hi = remainder.
  - Divide by zero: skip iteration, DONE next cycle, lo=32'hFFFFFFFF, hi=src_a. No exception raised.
  - DIV of 32'h80000000 by -1: lo=32'h80000000, hi=0 (wraps naturally).
- DONE: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in DONE, so back-to-back ops are spaced by one cycle.
- busy = (state != IDLE) & !(state==DONE).
- Flush:
  - flush in MUL/DIV/DONE -> IDLE next cycle; resp_valid suppressed, including the DONE cycle itself.
  - flush coincident with a request -> request dropped.
- Asynchronous reset mid-op: immediate return to reset values; no partial write.
- Outputs are registered; resp_* hold their last value outside resp_valid.

Optional Feature:
- Macro: MULTDIV_EARLY_DIV_EN.
- Defined: a DIV/DIVU where |src_a| < |src_b| (unsigned compare of magnitudes), divisor nonzero, skips iteration. DONE next cycle with lo=0, hi=src_a (original signed value).
- Undefined: all nonzero divides take the full DIV_ITERS+1 cycles.

Decomposition:
- Shared package (common): typedef md_state_t {IDLE,MUL,DIV,DONE}; typedef md_kind_t {MK_MUL,MK_DIV,MK_NONE}.
- Same package: function classifying decoded_op_t -> md_kind_t plus signed/accumulate/subtract flags, so decode and this block agree.
- One sub-module: div_radix2, unsigned restoring divider.
  - Ports: start, dividend, divisor, done, quotient, remainder.
  - Sign handling and the flush abort input live in multdiv_ctrl; div_radix2 receives a synchronous clear.
- Multiplier is inferred as a product register followed by a MUL_LAT-1 stage shift chain inside multdiv_ctrl.

Test Plan:
- MULT src_a=32'hFFFFFFFE(-2), src_b=3, MUL_LAT=3 -> resp_valid at cycle 4 after acceptance; hi=32'hFFFFFFFF, lo=32'hFFFFFFFA, hi_we=lo_we=1.
- MADDU hilo_in=64'h00000001_FFFFFFFF, a=1, b=1 -> hi=2, lo=0. MSUB hilo_in=0, a=2, b=3 -> {hi,lo}=64'hFFFFFFFF_FFFFFFFA.
- DIV a=-7, b=2 -> resp_valid 33 cycles after acceptance; lo=32'hFFFFFFFD(-3), hi=32'hFFFFFFFF(-1). DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=5, b=0 -> resp_valid 1 cycle after acceptance; lo=32'hFFFFFFFF, hi=5. With MULTDIV_EARLY_DIV_EN, DIVU a=3, b=9 -> 1 cycle; lo=0, hi=3.
- Issue DIV, assert flush at iteration 10 -> no resp_valid ever; req_ready=1 the following cycle; a new MULT accepted then completes correctly.
- MUL a=6, b=7 -> gpr_we=1, resp_lo=42, hi_we=lo_we=0. resetn pulsed low mid-DIV -> all outputs return to reset values immediately.
